// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared widths, ALU op-codes and sequencer state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_W      = 8;
    localparam int ALU_OPER_W = 3;

    localparam logic [ALU_OPER_W-1:0] ALU_OP_ADD = 3'd0;
    localparam logic [ALU_OPER_W-1:0] ALU_OP_SUB = 3'd1;
    localparam logic [ALU_OPER_W-1:0] ALU_OP_AND = 3'd2;
    localparam logic [ALU_OPER_W-1:0] ALU_OP_OR  = 3'd3;
    localparam logic [ALU_OPER_W-1:0] ALU_OP_XOR = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_byte_sequencer.sv
// ============================================================================
// Module : alu_byte_sequencer
// Brief  : Drives an 8-bit combinational ALU one byte per cycle, LSB first,
//          chaining carry, and returns the assembled wide result.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_byte_sequencer
    import alu_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NBYTES*ALU_W-1:0]   in_a,
    input  logic [NBYTES*ALU_W-1:0]   in_b,
    input  logic [ALU_OPER_W-1:0]     in_oper,
    input  logic                      in_c_in,
    output logic [ALU_W-1:0]          alu_a,
    output logic [ALU_W-1:0]          alu_b,
    output logic [ALU_OPER_W-1:0]     alu_oper,
    output logic                      alu_c_in,
    input  logic [ALU_W-1:0]          alu_sum,
    input  logic                      alu_c_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NBYTES*ALU_W-1:0]   out_result,
    output logic                      out_c_out,
    output logic                      busy
);

    localparam int W     = NBYTES * ALU_W;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NBYTES - 1);

    seq_state_e              r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [W-1:0]            r_a;
    logic [W-1:0]            r_b;
    logic [ALU_OPER_W-1:0]   r_oper;
    logic                    r_c_in;
    logic                    r_carry;
    logic [W-1:0]            r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_oper   <= '0;
            r_c_in   <= 1'b0;
            r_carry  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_oper  <= in_oper;
                        r_c_in  <= in_c_in;
                        r_idx   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_result[r_idx*ALU_W +: ALU_W] <= alu_sum;
                    r_carry                        <= alu_c_out;
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ALU inputs are a pure decode of registered state; zero outside RUN.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_oper = '0;
        alu_c_in = 1'b0;
        if (r_state == RUN) begin
            alu_a    = r_a[r_idx*ALU_W +: ALU_W];
            alu_b    = r_b[r_idx*ALU_W +: ALU_W];
            alu_oper = r_oper;
            alu_c_in = (r_idx == '0) ? r_c_in : r_carry;
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign out_valid  = (r_state == DONE);
    assign out_result = r_result;
    assign out_c_out  = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_alu_byte_sequencer.sv
// ============================================================================
// Module : tb_alu_byte_sequencer
// Brief  : Directed bench for alu_byte_sequencer (NBYTES=4 and NBYTES=1)
//          with a behavioural 8-bit ALU beside each instance.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_byte_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     = 1'b0;
    logic        sel       = 1'b0;
    logic        in_valid  = 1'b0;
    logic [31:0] in_a      = '0;
    logic [31:0] in_b      = '0;
    logic [2:0]  in_oper   = '0;
    logic        in_c_in   = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_valid4, in_ready4, busy4, out_valid4, out_c_out4;
    logic [31:0] out_result4;
    logic [7:0]  alu_a4, alu_b4, alu_sum4;
    logic [2:0]  alu_oper4;
    logic        alu_c_in4, alu_c_out4;

    logic        in_valid1, in_ready1, busy1, out_valid1, out_c_out1;
    logic [7:0]  out_result1;
    logic [7:0]  alu_a1, alu_b1, alu_sum1;
    logic [2:0]  alu_oper1;
    logic        alu_c_in1, alu_c_out1;

    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op, input logic ci);
        case (op)
            ALU_OP_ADD: return {1'b0, a} + {1'b0, b} + {8'd0, ci};
            ALU_OP_SUB: return {1'b0, a} + {1'b0, ~b} + {8'd0, ci};
            ALU_OP_AND: return {1'b0, a & b};
            ALU_OP_OR:  return {1'b0, a | b};
            ALU_OP_XOR: return {1'b0, a ^ b};
            default:    return {1'b0, a};
        endcase
    endfunction

    assign {alu_c_out4, alu_sum4} = alu_f(alu_a4, alu_b4, alu_oper4, alu_c_in4);
    assign {alu_c_out1, alu_sum1} = alu_f(alu_a1, alu_b1, alu_oper1, alu_c_in1);
    assign in_valid4 = in_valid & ~sel;
    assign in_valid1 = in_valid & sel;

    alu_byte_sequencer #(.NBYTES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_a(in_a), .in_b(in_b), .in_oper(in_oper), .in_c_in(in_c_in),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_oper(alu_oper4), .alu_c_in(alu_c_in4),
        .alu_sum(alu_sum4), .alu_c_out(alu_c_out4),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_result(out_result4), .out_c_out(out_c_out4), .busy(busy4)
    );

    alu_byte_sequencer #(.NBYTES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_oper(in_oper), .in_c_in(in_c_in),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_oper(alu_oper1), .alu_c_in(alu_c_in1),
        .alu_sum(alu_sum1), .alu_c_out(alu_c_out1),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_result(out_result1), .out_c_out(out_c_out1), .busy(busy1)
    );

    // Selected-instance view so tasks serve both widths.
    logic        m_ready, m_busy, m_valid, m_cout;
    logic [31:0] m_result;
    assign m_ready  = sel ? in_ready1  : in_ready4;
    assign m_busy   = sel ? busy1      : busy4;
    assign m_valid  = sel ? out_valid1 : out_valid4;
    assign m_cout   = sel ? out_c_out1 : out_c_out4;
    assign m_result = sel ? {24'd0, out_result1} : out_result4;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic ci);
        in_a = a; in_b = b; in_oper = op; in_c_in = ci; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!m_valid) chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic ci,
                          input logic [31:0] exp_r, input logic exp_c);
        send(a, b, op, ci);
        wait_done(tag);
        chk({tag, "_res"}, m_result, exp_r);
        chk({tag, "_cout"}, m_cout, exp_c);
        consume();
    endtask

    logic [31:0] v_a[3], v_b[3], v_r[3];
    logic [2:0]  v_op[3];
    logic        v_ci[3], v_co[3];

    task automatic b2b(input string tag, input int spacing);
        int  nreq = 0;
        int  nres = 0;
        int  last = 0;
        bit  pend = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && nres < 3; cyc++) begin
            if (m_valid) begin
                chk($sformatf("%s_res%0d", tag, nres), m_result, v_r[nres]);
                chk($sformatf("%s_cout%0d", tag, nres), m_cout, v_co[nres]);
                if (nres > 0) chk($sformatf("%s_gap%0d", tag, nres), cyc - last, spacing);
                last = cyc;
                nres++;
            end
            if (pend) nreq++;
            in_valid = (nreq < 3);
            if (nreq < 3) begin
                in_a = v_a[nreq]; in_b = v_b[nreq]; in_oper = v_op[nreq]; in_c_in = v_ci[nreq];
            end
            pend = in_valid && m_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk({tag, "_count"}, nres, 3);
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0] exp_ripple_cin [4];
    int         n_seen;

    initial begin
        // Reset state
        #12;
        chk("rst_in_ready", in_ready4, 1);
        chk("rst_busy", busy4, 0);
        chk("rst_out_valid", out_valid4, 0);
        chk("rst_out_result", out_result4, 0);
        chk("rst_alu_a", alu_a4, 0);
        chk("rst_alu_b", alu_b4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Carry ripple: 0xFFFFFFFF + 1
        exp_ripple_cin = '{8'd0, 8'd1, 8'd1, 8'd1};
        send(32'hFFFF_FFFF, 32'h0000_0001, ALU_OP_ADD, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ripple_cin%0d", k), alu_c_in4, exp_ripple_cin[k][0]);
            chk($sformatf("ripple_nvalid%0d", k), out_valid4, 0);
            @(negedge clk);
        end
        chk("ripple_latency_valid", out_valid4, 1);
        chk("ripple_res", out_result4, 32'h0000_0000);
        chk("ripple_cout", out_c_out4, 1);
        consume();

        // Carry-in into byte 0, every byte sums to 0x75
        send(32'h9D9D_9D9D, 32'hD7D7_D7D7, ALU_OP_ADD, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cin_sum%0d", k), alu_sum4, 8'h75);
            @(negedge clk);
        end
        chk("cin_res", out_result4, 32'h7575_7575);
        chk("cin_cout", out_c_out4, 1);
        consume();
        chk("cin_back_idle", in_ready4, 1);

        // Backpressure in DONE with a competing request
        send(32'h0000_0005, 32'h0000_0003, ALU_OP_SUB, 1'b1);
        wait_done("bp");
        in_a = 32'h1234_5678; in_b = 32'h1111_1111; in_oper = ALU_OP_ADD; in_c_in = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_valid%0d", k), out_valid4, 1);
            chk($sformatf("bp_res%0d", k), out_result4, 32'h0000_0002);
            chk($sformatf("bp_cout%0d", k), out_c_out4, 1);
            chk($sformatf("bp_ready%0d", k), in_ready4, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle_ready", in_ready4, 1);
        chk("bp_idle_busy", busy4, 0);
        chk("bp_idle_nvalid", out_valid4, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_accept_busy", busy4, 1);
        wait_done("bp2");
        chk("bp2_res", out_result4, 32'h2345_6789);
        chk("bp2_cout", out_c_out4, 0);
        consume();

        // Reset during RUN at idx 2
        send(32'h1122_3344, 32'h0000_0000, ALU_OP_ADD, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_alu_a_idx2", alu_a4, 8'h22);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy4, 0);
        chk("mid_rst_ready", in_ready4, 1);
        chk("mid_rst_result", out_result4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid4) n_seen++;
            @(negedge clk);
        end
        chk("mid_rst_no_valid", n_seen, 0);
        run_op("after_rst", 32'h8000_0000, 32'h8000_0001, ALU_OP_ADD, 1'b1, 32'h0000_0002, 1'b1);

        // Back-to-back, NBYTES=4
        v_a  = '{32'h0000_0001, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
        v_b  = '{32'h0000_0002, 32'hFFFF_FFFF, 32'h0F0F_0F0F};
        v_op = '{ALU_OP_ADD, ALU_OP_ADD, ALU_OP_AND};
        v_ci = '{1'b0, 1'b0, 1'b0};
        v_r  = '{32'h0000_0003, 32'hFFFF_FFFE, 32'h0E0D_0E0F};
        v_co = '{1'b0, 1'b1, 1'b0};
        b2b("b2b4", 6);

        // Back-to-back, NBYTES=1
        sel = 1'b1;
        @(negedge clk);
        v_a  = '{32'h7F, 32'hFF, 32'h03};
        v_b  = '{32'h01, 32'h01, 32'h05};
        v_op = '{ALU_OP_ADD, ALU_OP_ADD, ALU_OP_SUB};
        v_ci = '{1'b0, 1'b1, 1'b1};
        v_r  = '{32'h80, 32'h01, 32'hFE};
        v_co = '{1'b0, 1'b1, 1'b0};
        b2b("b2b1", 3);
        run_op("nb1_xor", 32'hF0, 32'h3C, ALU_OP_XOR, 1'b0, 32'hCC, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
